// File: rtl/ifc_arb_pkg.sv
// rtl/ifc_arb_pkg.sv - shared types and constants for the register-port arbiter
package ifc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int DEFAULT_ADDR_W = 3;
    localparam int DEFAULT_DATA_W = 1;
    localparam int CNT_W          = 8;

endpackage

// File: rtl/ifc_port_arbiter_rr_pick.sv
// rtl/ifc_port_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick
    import ifc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any
);

    // first requester at or above ptr, wrapping modulo NUM_REQ
    always_comb begin
        int idx;
        idx    = 0;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ifc_port_arbiter.sv
// rtl/ifc_port_arbiter.sv - shares the dut write/read ports among NUM_REQ requesters
module ifc_port_arbiter
    import ifc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     write_address,
    output logic [DATA_W-1:0]     write_data,
    output logic                  write_en,
    input  logic                  write_rdy,
    output logic [ADDR_W-1:0]     read_address,
    output logic                  read_en,
    input  logic [DATA_W-1:0]     read_data,
    input  logic                  read_rdy
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t          state, state_nxt;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     id_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt;

    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_id;
    logic                any;
    logic                op_rdy;
    logic                timed_out;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    assign op_rdy    = (state == ISSUE) && (wr_q ? write_rdy : read_rdy);
    assign timed_out = (state == ISSUE) && !op_rdy && (cnt == CNT_W'(TIMEOUT));

    // next state plus all dut-facing and requester-facing strobes
    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_data      = '0;
        rsp_err       = 1'b0;
        write_address = '0;
        write_data    = '0;
        write_en      = 1'b0;
        read_address  = '0;
        read_en       = 1'b0;
        case (state)
            IDLE: begin
                // gated so a pending request shows no accept while in reset
                req_ready = gnt & {NUM_REQ{~RST}};
                if (any) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (wr_q) begin
                    write_address = addr_q;
                    write_data    = wdata_q;
                    write_en      = write_rdy;
                end else begin
                    read_address  = addr_q;
                    read_en       = read_rdy;
                end
                if (op_rdy || timed_out) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = NUM_REQ'(1) << id_q;
                rsp_data  = rdata_q;
                rsp_err   = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register, request latch, stall counter and response registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            ptr     <= '0;
            id_q    <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any) begin
                        id_q    <= gnt_id;
                        wr_q    <= req_write[gnt_id];
                        addr_q  <= req_addr[gnt_id*ADDR_W +: ADDR_W];
                        wdata_q <= req_wdata[gnt_id*DATA_W +: DATA_W];
                        cnt     <= '0;
                    end
                end
                ISSUE: begin
                    if (op_rdy) begin
                        rdata_q <= wr_q ? '0 : read_data;
                        err_q   <= 1'b0;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    // fairness pointer moves only once a grant has completed
                    ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifc_port_arbiter.sv
// tb/tb_ifc_port_arbiter.sv - self-checking bench for ifc_port_arbiter
module tb_ifc_port_arbiter;

    localparam int N       = 4;
    localparam int AW      = 3;
    localparam int DW      = 1;
    localparam int TIMEOUT = 15;

    logic          CLK;
    logic          RST;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic          write_en;
    logic          write_rdy;
    logic [AW-1:0] read_address;
    logic          read_en;
    logic [DW-1:0] read_data;
    logic          read_rdy;

    int checks   = 0;
    int failures = 0;

    ifc_port_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // register file standing in for the dut
    logic [7:0] dmem;
    logic       mem_clear;
    always @(posedge CLK) begin
        if (mem_clear) dmem <= '0;
        else if (write_en) dmem[write_address] <= write_data;
    end
    assign read_data = dmem[read_address];

    logic [18:0] outs;
    assign outs = {req_ready, rsp_valid, rsp_data, rsp_err, write_en, write_address,
                   write_data, read_en, read_address};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int rid;
        bit wr;
        int addr;
        bit wd;
        int stall;
        int lat;
        bit data;
        bit err;
    } vec_t;

    vec_t vecs[11];

    // one isolated transaction: rdy low for 'stall' ISSUE cycles, then high
    task automatic run_vec(input vec_t v, input int idx);
        int  got;
        bit  en_ok;
        bit  fire;
        logic [8:0] exp_io;
        logic [8:0] act_io;
        got   = -1;
        en_ok = 1'b1;
        @(negedge CLK);
        req_valid = '0;
        req_valid[v.rid] = 1'b1;
        req_write[v.rid] = v.wr;
        req_addr[v.rid*AW +: AW] = AW'(v.addr);
        req_wdata[v.rid] = v.wd;
        write_rdy = 1'b1;
        read_rdy  = 1'b1;
        #1;
        check($sformatf("vec%0d_ready", idx), 32'(req_ready), 32'(N'(1) << v.rid));
        for (int k = 1; k <= 40 && got < 0; k++) begin
            @(negedge CLK);
            req_valid = '0;
            if (v.wr) begin
                write_rdy = (k > v.stall);
                read_rdy  = 1'b1;
            end else begin
                read_rdy  = (k > v.stall);
                write_rdy = 1'b1;
            end
            #1;
            if (rsp_valid != '0) begin
                got = k;
                check($sformatf("vec%0d_rsp_id", idx), 32'(rsp_valid), 32'(N'(1) << v.rid));
                check($sformatf("vec%0d_rsp_data", idx), 32'(rsp_data), 32'(v.data));
                check($sformatf("vec%0d_rsp_err", idx), 32'(rsp_err), 32'(v.err));
            end else if (k < v.lat) begin
                fire   = (v.stall <= TIMEOUT) && (k == v.stall + 1);
                exp_io = {v.wr && fire, !v.wr && fire,
                          v.wr ? AW'(v.addr) : AW'(0), v.wr ? v.wd : 1'b0,
                          v.wr ? AW'(0) : AW'(v.addr)};
                act_io = {write_en, read_en, write_address, write_data, read_address};
                if (act_io !== exp_io) en_ok = 1'b0;
            end
        end
        check($sformatf("vec%0d_latency", idx), 32'(got), 32'(v.lat));
        check($sformatf("vec%0d_dut_port", idx), 32'(en_ok), 32'd1);
    endtask

    // behavioural model state for the random phase
    int         m_ptr, m_id, m_addr, m_A, m_resp_at, last_grant, drought;
    bit         m_busy, m_wr, m_wd, m_rdat, m_rerr;
    logic [7:0] m_mem;

    initial begin
        RST       = 1'b1;
        mem_clear = 1'b1;
        req_valid = 4'b1111;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        write_rdy = 1'b1;
        read_rdy  = 1'b1;

        // reset values, with requests already pending
        repeat (2) @(negedge CLK);
        #1;
        check("reset_outputs", 32'(outs), 32'd0);
        req_valid = '0;
        @(negedge CLK);
        RST       = 1'b0;
        mem_clear = 1'b0;
        #1;
        check("idle_outputs", 32'(outs), 32'd0);

        // round robin: all four hold writes, ptr starts at 0
        @(negedge CLK);
        for (int i = 0; i < N; i++) begin
            req_write[i] = 1'b1;
            req_addr[i*AW +: AW] = AW'(i);
            req_wdata[i] = 1'b1;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge CLK);
            if (k == 13) req_valid = '0;
            #1;
            check($sformatf("rr_ready_%0d", k), 32'(req_ready),
                  (k % 3 == 0) ? 32'(N'(1) << ((k / 3) % N)) : 32'd0);
            check($sformatf("rr_rsp_%0d", k), 32'({rsp_valid, rsp_err}),
                  (k % 3 == 2) ? 32'({N'(1) << ((k / 3) % N), 1'b0}) : 32'd0);
            check($sformatf("rr_excl_%0d", k), 32'(write_en & read_en), 32'd0);
        end

        // directed transactions: rid, wr, addr, wdata, stall, latency, rdata, err
        vecs[0]  = '{0, 1'b1, 3, 1'b1, 0,  2,  1'b0, 1'b0};
        vecs[1]  = '{1, 1'b0, 3, 1'b0, 0,  2,  1'b1, 1'b0};
        vecs[2]  = '{2, 1'b1, 5, 1'b1, 4,  6,  1'b0, 1'b0};
        vecs[3]  = '{2, 1'b0, 5, 1'b0, 0,  2,  1'b1, 1'b0};
        vecs[4]  = '{3, 1'b0, 6, 1'b0, 20, 17, 1'b0, 1'b1};
        vecs[5]  = '{3, 1'b1, 7, 1'b0, 15, 17, 1'b0, 1'b0};
        vecs[6]  = '{1, 1'b0, 7, 1'b0, 0,  2,  1'b0, 1'b0};
        vecs[7]  = '{0, 1'b1, 0, 1'b1, 1,  3,  1'b0, 1'b0};
        vecs[8]  = '{0, 1'b0, 0, 1'b0, 0,  2,  1'b1, 1'b0};
        vecs[9]  = '{3, 1'b1, 6, 1'b1, 14, 16, 1'b0, 1'b0};
        vecs[10] = '{2, 1'b0, 6, 1'b0, 0,  2,  1'b1, 1'b0};
        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // reset in the middle of a stalled read from requester 2 (ptr is now 3)
        @(negedge CLK);
        req_valid = 4'b0100;
        req_write[2] = 1'b0;
        req_addr[2*AW +: AW] = 3'd5;
        read_rdy  = 1'b0;
        write_rdy = 1'b0;
        #1;
        check("rst_accept", 32'(req_ready), 32'(4'b0100));
        @(negedge CLK);
        req_valid = 4'b0010;
        @(negedge CLK);
        #1;
        check("rst_pre_addr", 32'(read_address), 32'd5);
        RST = 1'b1;
        #1;
        check("rst_async_outputs", 32'(outs), 32'd0);
        repeat (2) @(negedge CLK);
        #1;
        check("rst_held_outputs", 32'(outs), 32'd0);
        @(negedge CLK);
        RST       = 1'b0;
        req_valid = '0;
        read_rdy  = 1'b1;
        write_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rst_no_rsp_%0d", k), 32'(outs), 32'd0);
            @(negedge CLK);
        end
        req_valid = 4'b1011;
        #1;
        check("rst_next_grant", 32'(req_ready), 32'(4'b0001));

        // random traffic against the transaction-level model
        @(negedge CLK);
        RST       = 1'b1;
        mem_clear = 1'b1;
        req_valid = '0;
        @(negedge CLK);
        @(negedge CLK);
        RST        = 1'b0;
        mem_clear  = 1'b0;
        m_ptr      = 0;
        m_busy     = 1'b0;
        m_mem      = '0;
        m_resp_at  = -1;
        last_grant = -1;
        drought    = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [3:0] e_ready, e_rsp;
            logic       e_rdata, e_err, e_wen, e_wdata, e_ren, rdy;
            logic [2:0] e_waddr, e_raddr;
            int         g;
            if (cyc > 0) @(negedge CLK);
            for (int i = 0; i < N; i++) begin
                if (last_grant == i) req_valid[i] = 1'b0;
                if (!req_valid[i]) begin
                    if ($urandom % 3 == 0) begin
                        req_valid[i] = 1'b1;
                        req_write[i] = 1'($urandom % 2);
                        req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
                        req_wdata[i] = 1'($urandom % 2);
                    end
                end else if ($urandom % 24 == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            last_grant = -1;
            if (drought > 0) begin
                drought--;
                write_rdy = 1'b0;
                read_rdy  = 1'b0;
            end else begin
                if ($urandom % 50 == 0) drought = $urandom_range(10, 20);
                write_rdy = ($urandom % 3 != 0);
                read_rdy  = ($urandom % 3 != 0);
            end
            #1;
            e_ready = '0; e_rsp = '0; e_rdata = 0; e_err = 0; e_wen = 0;
            e_wdata = 0; e_ren = 0; e_waddr = '0; e_raddr = '0;
            if (m_busy && cyc == m_resp_at) begin
                e_rsp   = 4'(1) << m_id;
                e_rdata = m_rdat;
                e_err   = m_rerr;
                m_ptr   = (m_id + 1) % N;
                m_busy  = 1'b0;
            end else if (m_busy && m_resp_at < 0) begin
                rdy = m_wr ? write_rdy : read_rdy;
                if (m_wr) begin
                    e_waddr = 3'(m_addr);
                    e_wdata = m_wd;
                end else begin
                    e_raddr = 3'(m_addr);
                end
                if (rdy) begin
                    if (m_wr) begin
                        e_wen = 1'b1;
                        m_rdat = 1'b0;
                        m_mem[m_addr] = m_wd;
                    end else begin
                        e_ren = 1'b1;
                        m_rdat = m_mem[m_addr];
                    end
                    m_rerr    = 1'b0;
                    m_resp_at = cyc + 1;
                end else if (cyc - m_A - 1 == TIMEOUT) begin
                    m_rdat    = 1'b0;
                    m_rerr    = 1'b1;
                    m_resp_at = cyc + 1;
                end
            end else if (!m_busy) begin
                g = -1;
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
                if (g >= 0) begin
                    e_ready    = 4'(1) << g;
                    m_id       = g;
                    m_wr       = req_write[g];
                    m_addr     = int'(req_addr[g*AW +: AW]);
                    m_wd       = req_wdata[g];
                    m_A        = cyc;
                    m_resp_at  = -1;
                    m_busy     = 1'b1;
                    last_grant = g;
                end
            end
            check($sformatf("rand_cyc%0d", cyc), 32'(outs),
                  32'({e_ready, e_rsp, e_rdata, e_err, e_wen, e_waddr, e_wdata, e_ren, e_raddr}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
